seq_detect_ctrl: RTL and testbench

Programmable sequence-detection controller that configures, arms, feeds and retires a bit-serial pattern matcher. It holds a pattern of up to PAT_W bits, accepts one serial bit per handshake, emits a one-cycle match pulse and counts matches. It stops on a target count, on abort, or optionally on an idle timeout. It sits between a serial bit source and a status/interrupt consumer, replacing a hard-wired fixed-pattern detector.

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/seq_match_core.sv | 50 +++++
 rtl/seq_detect_ctrl.sv | 159 +++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and reset defaults for the sequence-detection controller.
package seq_detect_pkg;

    // Controller states; encodings are fixed so status decoders can rely on them.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StArm  = 2'b01,
        StRun  = 2'b10,
        StDone = 2'b11
    } state_t;

    // Out of reset the block detects the pattern 101 with overlapping matches.
    localparam logic [2:0]  DefPat     = 3'b101;
    localparam int unsigned DefLen     = 3;
    localparam logic        DefOverlap = 1'b1;

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial history register with fill counter and masked pattern compare.
// The match output looks at the history as it will be after the current bit
// shifts in, so the controller can act on the same edge that accepts the bit.
module seq_match_core #(
    parameter int unsigned  PAT_W = 8,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             match
);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_inc;

    // Next history, saturating fill and the low-len-bits compare mask.
    always_comb begin
        hist_nxt = {hist_q[PAT_W-2:0], din};
        fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
        mask     = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
        match = shift_en && (fill_inc >= len) && (((hist_nxt ^ pat) & mask) == '0);
    end

    // History shifts on accepted bits; without overlap a match restarts the fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_nxt;
            fill_q <= (match && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable sequence-detection controller: configuration, arm/run/done
// sequencing, match counting and status outputs around seq_match_core.
// Optional idle timeout is built only when SEQDET_TIMEOUT_EN is defined.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int unsigned  PAT_W = 8,
    parameter int unsigned  CNT_W = 8,
    parameter int unsigned  TO_W  = 16,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic             x_valid,
    input  logic             x,
    output logic             x_ready,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             timeout
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             cfg_err_q;
    logic             z_q, busy_q, done_q, ready_q;
    logic             accept, core_match, hit, tgt_hit, to_hit;
    logic             cfg_open, cfg_legal;

    assign accept    = x_valid & ready_q;
    assign hit       = accept & core_match;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign tgt_hit   = hit && (target_q != '0) && (cnt_inc == target_q);
    assign cfg_open  = (state_q == StIdle) || (state_q == StDone);
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == StArm),
        .shift_en (accept),
        .din      (x),
        .overlap  (overlap_q),
        .pat      (pat_q),
        .len      (len_q),
        .match    (core_match)
    );

`ifdef SEQDET_TIMEOUT_EN
    logic [TO_W-1:0] to_val_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    assign to_hit = (state_q == StRun) && !hit && (to_val_q != '0) &&
                    ((to_cnt_q + TO_W'(1)) == to_val_q);

    // Idle counter runs in RUN, restarts on a match, latches the timeout cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_val_q  <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (cfg_we && cfg_open && cfg_legal) to_val_q <= cfg_timeout;
            if (state_q == StArm || hit)         to_cnt_q <= '0;
            else if (state_q == StRun)           to_cnt_q <= to_cnt_q + TO_W'(1);
            if (state_d == StArm || state_d == StIdle) timeout_q <= 1'b0;
            else if (!abort && to_hit)                 timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
    assign to_hit             = 1'b0;
    assign timeout            = 1'b0;
`endif

    // Next-state decode; abort wins over everything, start needs a clean config.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start && !cfg_err_q) state_d = StArm;
                StArm:   state_d = StRun;
                StRun:   if (tgt_hit || to_hit) state_d = StDone;
                StDone:  if (start && !cfg_err_q) state_d = StArm;
                default: state_d = StIdle;
            endcase
        end
    end

    // State, registered status outputs, configuration and match counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            z_q       <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            pat_q     <= PAT_W'(DefPat);
            len_q     <= LEN_W'(DefLen);
            overlap_q <= DefOverlap;
            target_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == StArm) || (state_d == StRun);
            done_q  <= (state_d == StDone);
            ready_q <= (state_d == StRun);
            z_q     <= hit && !abort;
            if (cfg_we && cfg_open) begin
                if (cfg_legal) begin
                    pat_q     <= cfg_pat;
                    len_q     <= cfg_len;
                    overlap_q <= cfg_overlap;
                    target_q  <= cfg_target;
                    cfg_err_q <= 1'b0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
            // Abort keeps the count so software can read how far the run got.
            if (!abort) begin
                if (state_q == StArm) cnt_q <= '0;
                else if (hit)         cnt_q <= cnt_inc;
            end
        end
    end

    assign x_ready   = ready_q;
    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; honours SEQDET_TIMEOUT_EN like the RTL.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pat = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic [15:0] cfg_timeout = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       x_valid = 1'b0;
    logic       x = 1'b0;
    logic       x_ready, z, busy, done, cfg_err, timeout;
    logic [7:0] match_cnt;

    int errors = 0;
    int checks = 0;

    seq_detect_ctrl #(
        .PAT_W (8),
        .CNT_W (8),
        .TO_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pat     (cfg_pat),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .start       (start),
        .abort       (abort),
        .x_valid     (x_valid),
        .x           (x),
        .x_ready     (x_ready),
        .z           (z),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                          input logic [7:0] t, input logic [15:0] to);
        cfg_pat = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_timeout = to;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    // start pulse, then one ARM cycle; returns with the block in RUN
    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic send(input logic b);
        x_valid = 1'b1; x = b;
        step();
        x_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(x_ready), 0);
        check("rst_cnt", 32'(match_cnt), 0);
        check("rst_z", 32'(z), 0);
        step();
        rst = 1'b1;
        step();

        // Default pattern 101, overlapping
        start = 1'b1; step(); start = 1'b0;
        check("arm_busy", 32'(busy), 1);
        check("arm_ready", 32'(x_ready), 0);
        step();
        check("run_ready", 32'(x_ready), 1);
        send(1); check("t1_b1_z", 32'(z), 0);
        send(0); check("t1_b2_z", 32'(z), 0);
        send(1); check("t1_b3_z", 32'(z), 1);
        send(0); check("t1_b4_z", 32'(z), 0);
        send(1); check("t1_b5_z", 32'(z), 1);
        step();  check("t1_z_fall", 32'(z), 0);
        check("t1_cnt", 32'(match_cnt), 2);
        do_abort();
        check("t1_abort_busy", 32'(busy), 0);
        check("t1_abort_cnt_kept", 32'(match_cnt), 2);

        // 1101, len 4, no overlap
        do_cfg(8'b0000_1101, 4'd4, 1'b0, 8'd0, 16'd0);
        arm();
        send(1); send(1); send(0);
        check("t2_b3_z", 32'(z), 0);
        send(1); check("t2_b4_z", 32'(z), 1);
        send(1); send(0);
        send(1); check("t2_b7_z", 32'(z), 0);
        check("t2_cnt", 32'(match_cnt), 1);
        do_abort();

        // Target 2 with 101
        do_cfg(8'b0000_0101, 4'd3, 1'b1, 8'd2, 16'd0);
        arm();
        send(1); send(0); send(1);
        check("t3_b3_z", 32'(z), 1);
        check("t3_b3_done", 32'(done), 0);
        send(1); send(0); send(1);
        check("t3_b6_z", 32'(z), 1);
        check("t3_b6_done", 32'(done), 1);
        check("t3_b6_ready", 32'(x_ready), 0);
        check("t3_b6_cnt", 32'(match_cnt), 2);
        send(1);
        check("t3_b7_cnt", 32'(match_cnt), 2);
        check("t3_b7_z", 32'(z), 0);
        check("t3_b7_done", 32'(done), 1);

        // Illegal configuration
        do_cfg(8'b0000_0101, 4'd0, 1'b1, 8'd0, 16'd0);
        check("t4_err_len0", 32'(cfg_err), 1);
        start = 1'b1; step(); start = 1'b0;
        step();
        check("t4_start_ignored", 32'(busy), 0);
        do_cfg(8'b0000_0101, 4'd9, 1'b1, 8'd0, 16'd0);
        check("t4_err_len9", 32'(cfg_err), 1);
        do_cfg(8'b0000_0101, 4'd3, 1'b1, 8'd0, 16'd0);
        check("t4_err_clear", 32'(cfg_err), 0);

        // Abort beats start; ARM clears history
        arm();
        check("t5_cnt_cleared", 32'(match_cnt), 0);
        send(1); send(0);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_ready", 32'(x_ready), 0);
        check("t5_done", 32'(done), 0);
        arm();
        send(1); check("t5_no_match", 32'(z), 0);
        send(0); send(1); check("t5_match", 32'(z), 1);
        check("t5_cnt", 32'(match_cnt), 1);
        do_abort();

        // Idle timeout of 4 cycles
        do_cfg(8'b0000_0101, 4'd3, 1'b1, 8'd0, 16'd4);
        arm();
        step(); step(); step();
        check("t6_pre_done", 32'(done), 0);
        step();
`ifdef SEQDET_TIMEOUT_EN
        check("t6_done", 32'(done), 1);
        check("t6_timeout", 32'(timeout), 1);
        check("t6_ready", 32'(x_ready), 0);
        start = 1'b1; step(); start = 1'b0;
        check("t6_timeout_clr", 32'(timeout), 0);
        step();
`else
        check("t6_done", 32'(done), 0);
        check("t6_timeout", 32'(timeout), 0);
        check("t6_busy", 32'(busy), 1);
`endif
        do_abort();

        // Asynchronous reset mid-RUN
        do_cfg(8'b0000_0101, 4'd3, 1'b1, 8'd0, 16'd0);
        arm();
        send(1); send(0); send(1);
        check("t7_cnt", 32'(match_cnt), 1);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_ready", 32'(x_ready), 0);
        check("t7_rst_z", 32'(z), 0);
        check("t7_rst_cnt", 32'(match_cnt), 0);
        step();
        rst = 1'b1;
        step();
        check("t7_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
